// File: rtl/bp_stall_profile_counters.sv
// Stall-reason profile counters with a single-outstanding read port.
// One saturating counter per stall reason, plus instret, cycle and sticky status.
module bp_stall_profile_counters #(
  parameter int num_reasons_p = 33,
  parameter int ctr_width_p   = 32,
  parameter int addr_width_p  = 6
) (
  input  logic                    clk_i,
  input  logic                    reset_li,
  input  logic                    freeze_i,
  input  logic                    event_v_i,
  input  logic                    instret_i,
  input  logic [5:0]              stall_reason_i,
  input  logic                    clear_i,
  input  logic                    rd_v_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  output logic                    rd_ready_o,
  output logic                    rd_data_v_o,
  output logic [ctr_width_p-1:0]  rd_data_o,
  input  logic                    rd_data_yumi_i
);

  typedef logic [ctr_width_p-1:0] ctr_t;
  typedef enum logic {e_idle, e_resp} state_e;

  localparam ctr_t ctr_max_lp      = '1;
  localparam int   instret_addr_lp = num_reasons_p;
  localparam int   cycle_addr_lp   = num_reasons_p + 1;
  localparam int   status_addr_lp  = num_reasons_p + 2;

  ctr_t       reason_q [num_reasons_p];
  ctr_t       reason_d [num_reasons_p];
  ctr_t       instret_q, instret_d;
  ctr_t       cycle_q, cycle_d;
  ctr_t       rd_data_q, rd_data_d;
  ctr_t       rd_val;
  logic [1:0] status_q, status_d;   // {saturated, bad_reason}
  state_e     state_q, state_d;
  logic       init_q;
  int         sel;
  logic       bad_reason;

  function automatic ctr_t sat_inc(input ctr_t v);
    return (v == ctr_max_lp) ? v : v + ctr_t'(1);
  endfunction

  always_comb begin
    reason_d   = reason_q;
    instret_d  = instret_q;
    cycle_d    = cycle_q;
    status_d   = status_q;
    sel        = 0;
    bad_reason = 1'b0;
    if (int'(stall_reason_i) < num_reasons_p) sel = int'(stall_reason_i);
    else                                      bad_reason = 1'b1;

    if (clear_i) begin
      for (int i = 0; i < num_reasons_p; i++) reason_d[i] = '0;
      instret_d = '0;
      cycle_d   = '0;
      status_d  = '0;
    end else if (!freeze_i) begin
      cycle_d = sat_inc(cycle_q);
      if (cycle_q == ctr_max_lp) status_d[1] = 1'b1;
      if (event_v_i && instret_i) begin
        instret_d = sat_inc(instret_q);
        if (instret_q == ctr_max_lp) status_d[1] = 1'b1;
      end else if (event_v_i) begin
        // Out-of-range reasons are folded into the "unknown" counter.
        for (int i = 0; i < num_reasons_p; i++) begin
          if (i == sel) begin
            reason_d[i] = sat_inc(reason_q[i]);
            if (reason_q[i] == ctr_max_lp) status_d[1] = 1'b1;
          end
        end
        if (bad_reason) status_d[0] = 1'b1;
      end
    end
  end

  // Read mux sees the registered values, i.e. before this cycle's update.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < num_reasons_p; i++)
      if (int'(rd_addr_i) == i) rd_val = reason_q[i];
    if (int'(rd_addr_i) == instret_addr_lp) rd_val = instret_q;
    if (int'(rd_addr_i) == cycle_addr_lp)   rd_val = cycle_q;
    if (int'(rd_addr_i) == status_addr_lp)  rd_val = ctr_t'(status_q);
  end

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    case (state_q)
      e_idle: if (rd_v_i && init_q) begin
        rd_data_d = rd_val;
        state_d   = e_resp;
      end
      e_resp: if (rd_data_yumi_i) state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      for (int i = 0; i < num_reasons_p; i++) reason_q[i] <= '0;
      instret_q <= '0;
      cycle_q   <= '0;
      status_q  <= '0;
      rd_data_q <= '0;
      state_q   <= e_idle;
      init_q    <= 1'b0;
    end else begin
      reason_q  <= reason_d;
      instret_q <= instret_d;
      cycle_q   <= cycle_d;
      status_q  <= status_d;
      rd_data_q <= rd_data_d;
      state_q   <= state_d;
      init_q    <= 1'b1;
    end
  end

  assign rd_ready_o  = init_q && (state_q == e_idle);
  assign rd_data_v_o = (state_q == e_resp);
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_bp_stall_profile_counters.sv
// Bench for bp_stall_profile_counters: a 32-bit and a 4-bit instance share one event
// stream and are checked against an array-based reference model.
module tb_bp_stall_profile_counters;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, frz = 1'b0, ev = 1'b0, ins = 1'b0, clr = 1'b0;
  logic [5:0] rsn = '0;
  logic       rv0 = 1'b0, ry0 = 1'b0, rv1 = 1'b0, ry1 = 1'b0;
  logic [5:0] ra0 = '0, ra1 = '0;
  logic       rr0, rdv0, rr1, rdv1;
  logic [31:0] rd0;
  logic [3:0]  rd1;

  int checks = 0;
  int errors = 0;

  bp_stall_profile_counters dut0 (
    .clk_i(clk), .reset_li(rst_n), .freeze_i(frz), .event_v_i(ev), .instret_i(ins),
    .stall_reason_i(rsn), .clear_i(clr), .rd_v_i(rv0), .rd_addr_i(ra0),
    .rd_ready_o(rr0), .rd_data_v_o(rdv0), .rd_data_o(rd0), .rd_data_yumi_i(ry0));

  bp_stall_profile_counters #(.ctr_width_p(4)) dut1 (
    .clk_i(clk), .reset_li(rst_n), .freeze_i(frz), .event_v_i(ev), .instret_i(ins),
    .stall_reason_i(rsn), .clear_i(clr), .rd_v_i(rv1), .rd_addr_i(ra1),
    .rd_ready_o(rr1), .rd_data_v_o(rdv1), .rd_data_o(rd1), .rd_data_yumi_i(ry1));

  // Reference model: index 0..32 reasons, 33 instret, 34 cycle.
  longint cnt [2][35];
  bit     bad [2];
  bit     sat [2];
  longint cmax [2];

  task automatic mzero();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 35; i++) cnt[w][i] = 0;
      bad[w] = 0;
      sat[w] = 0;
    end
  endtask

  task automatic minc(int w, int i);
    if (cnt[w][i] >= cmax[w]) sat[w] = 1;
    else cnt[w][i] = cnt[w][i] + 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) mzero();
    else if (!frz) begin
      for (int w = 0; w < 2; w++) begin
        minc(w, 34);
        if (ev) begin
          if (ins) minc(w, 33);
          else if (rsn < 6'd33) minc(w, int'(rsn));
          else begin
            minc(w, 0);
            bad[w] = 1;
          end
        end
      end
    end
  end

  function automatic logic [63:0] mval(int w, int a);
    if (a < 35) return 64'(cnt[w][a]);
    if (a == 35) return 64'(2 * int'(sat[w]) + int'(bad[w]));
    return 64'd0;
  endfunction

  function automatic logic [63:0] dobs(int w);
    return (w != 0) ? {60'd0, rd1} : {32'd0, rd0};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(bit e, bit i, int r, bit f, bit c);
    ev = e; ins = i; rsn = 6'(r); frz = f; clr = c;
    @(posedge clk); #1;
    ev = 0; ins = 0; frz = 0; clr = 0;
  endtask

  task automatic rd(int w, int a, int hold);
    logic [63:0] exp;
    exp = mval(w, a);
    if (w == 0) begin rv0 = 1; ra0 = 6'(a); end
    else        begin rv1 = 1; ra1 = 6'(a); end
    chk($sformatf("ready_before_req w%0d a%0d", w, a), (w != 0) ? rr1 : rr0, 1);
    @(posedge clk); #1;
    rv0 = 0; rv1 = 0; ev = 0;
    chk($sformatf("rsp_valid w%0d a%0d", w, a), (w != 0) ? rdv1 : rdv0, 1);
    chk($sformatf("rsp_data w%0d a%0d", w, a), dobs(w), exp);
    chk($sformatf("ready_busy w%0d a%0d", w, a), (w != 0) ? rr1 : rr0, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_data w%0d a%0d c%0d", w, a, h), dobs(w), exp);
      chk($sformatf("hold_ready w%0d c%0d", w, h), (w != 0) ? rr1 : rr0, 0);
      chk($sformatf("hold_valid w%0d c%0d", w, h), (w != 0) ? rdv1 : rdv0, 1);
    end
    if (w == 0) ry0 = 1; else ry1 = 1;
    @(posedge clk); #1;
    ry0 = 0; ry1 = 0;
    chk($sformatf("idle_valid w%0d", w), (w != 0) ? rdv1 : rdv0, 0);
    chk($sformatf("idle_ready w%0d", w), (w != 0) ? rr1 : rr0, 1);
    chk($sformatf("idle_data_held w%0d", w), dobs(w), exp);
  endtask

  initial begin
    cmax[0] = 64'hFFFF_FFFF;
    cmax[1] = 15;
    mzero();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rr0, 0);
    chk("rst_valid", rdv0, 0);
    chk("rst_data", rd0, 0);
    #3 rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_release", rr0, 1);
    chk("ready_after_release_small", rr1, 1);

    // Ten idle cycles since reset, then basic reads
    repeat (9) cyc(0, 0, 0, 0, 0);
    rd(0, 34, 0);
    rd(0, 33, 0);
    rd(0, 35, 0);

    // Instret and reason counting
    cyc(0, 0, 0, 0, 1);
    repeat (5) cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 6, 0, 0);
    repeat (2) cyc(1, 0, 32, 0, 0);
    rd(0, 33, 0);
    rd(0, 6, 0);
    rd(0, 32, 0);
    rd(0, 0, 0);

    // Out-of-range reason, then clear racing an event
    cyc(1, 0, 40, 0, 0);
    rd(0, 0, 0);
    rd(0, 35, 0);
    cyc(1, 0, 6, 0, 1);
    rd(0, 0, 0);
    rd(0, 6, 0);
    rd(0, 35, 0);

    // Saturation on the 4-bit instance
    cyc(0, 0, 0, 0, 1);
    repeat (20) cyc(1, 0, 1, 0, 0);
    rd(1, 1, 0);
    rd(1, 35, 0);
    repeat (5) cyc(1, 0, 1, 0, 0);
    rd(1, 1, 0);

    // Response held under back-pressure; read concurrent with an increment
    rd(0, 34, 4);
    ev = 1; ins = 0; rsn = 6'd6;
    rd(0, 6, 0);
    rd(0, 6, 0);

    // Freeze leaves the cycle counter alone
    rd(0, 34, 0);
    repeat (8) cyc(1, 0, 6, 1, 0);
    rd(0, 34, 0);
    rd(0, 6, 0);

    // Stray yumi while idle is ignored
    ry0 = 1;
    @(posedge clk); #1;
    ry0 = 0;
    chk("stray_yumi_ready", rr0, 1);
    chk("stray_yumi_valid", rdv0, 0);

    // Randomized traffic, then sweep the whole address map
    for (int k = 0; k < 400; k++) begin
      ev  = 1'($urandom_range(0, 1));
      ins = ($urandom_range(0, 3) == 0);
      rsn = 6'($urandom_range(0, 63));
      frz = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    ev = 0; ins = 0; frz = 0; clr = 0;
    for (int a = 0; a < 64; a++) rd(0, a, 0);
    for (int a = 0; a < 36; a++) rd(1, a, 0);

    // Async reset while a response is pending
    repeat (3) cyc(1, 0, 6, 0, 0);
    rv0 = 1; ra0 = 6'd34;
    @(posedge clk); #1;
    rv0 = 0;
    chk("resp_before_reset", rdv0, 1);
    #2 rst_n = 0;
    #1;
    chk("reset_drops_valid", rdv0, 0);
    chk("reset_ready_low", rr0, 0);
    chk("reset_data_zero", rd0, 0);
    @(posedge clk); #1;
    chk("in_reset_ready_low", rr0, 0);
    #3 rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_midread_reset", rr0, 1);
    rd(0, 6, 0);
    rd(0, 33, 0);
    rd(0, 34, 0);
    rd(0, 35, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_stall_profile_counters.md
Name: bp_stall_profile_counters

Overview:
- Synthesizable consumer of the per-cycle stall-reason stream produced by the core profiler.
- Per cycle it takes one event: either an instruction retire or a 6-bit encoded stall reason, using the same 33-entry encoding (0=unknown … 32=fe_queue_full).
- Keeps one saturating counter per reason, plus an instret counter and a cycle counter.
- A host-side reader (Zynq shell, AXI-lite bridge) reads the counters over a single-outstanding valid/ready request/response port.

Parameters:
- num_reasons_p, 33, number of encoded stall reasons (indices 0..num_reasons_p-1).
- ctr_width_p, 32, width of every counter and of rd_data_o.
- addr_width_p, 6, width of rd_addr_i.

Ports:
- clk_i  in  1  clock.
- reset_li  in  1  reset, asynchronous, active-low; clock clk_i.
- freeze_i  in  1  core frozen; no counting while high.
- event_v_i  in  1  one profiler event this cycle.
- instret_i  in  1  event is a retired instruction (stall_reason_i ignored).
- stall_reason_i  in  6  encoded stall reason, valid when event_v_i & ~instret_i.
- clear_i  in  1  synchronous clear of all counters and sticky status.
- rd_v_i  in  1  read request valid.
- rd_addr_i  in  addr_width_p  counter address.
- rd_ready_o  out  1  request accepted when rd_v_i & rd_ready_o.
- rd_data_v_o  out  1  response valid.
- rd_data_o  out  ctr_width_p  response data.
- rd_data_yumi_i  in  1  response consumed; legal only while rd_data_v_o=1.

Behaviour:
- Reset (reset_li=0, async):
  - All counters, status bits and response register go to 0.
  - FSM goes to IDLE.
  - Outputs: rd_ready_o=0 while in reset, 1 after the first clk_i edge out of reset; rd_data_v_o=0; rd_data_o=0.
- Counting, in cycles with freeze_i=0 and clear_i=0:
  - cycle counter +1 every such cycle.
  - If event_v_i & instret_i: instret counter +1.
  - If event_v_i & ~instret_i: reason counter[stall_reason_i] +1.
  - stall_reason_i >= num_reasons_p: count goes to counter[0] (unknown) and sticky status bit0 (bad_reason) is set.
  - At most one reason counter increments per cycle.
- Saturation: a counter at 2^ctr_width_p-1 holds its value and sets sticky status bit1 (saturated). Counters never wrap.
- freeze_i=1: no counter changes, including the cycle counter. The read port stays fully functional.
- clear_i=1: at the next edge all counters and status bits become 0. Clear wins over a same-cycle event; that event is dropped. A response already latched is unaffected.
- Address map:
  - 0..num_reasons_p-1: reason counters.
  - num_reasons_p (33): instret.
  - 34: cycle.
  - 35: status, {ctr_width_p-2 zeros, saturated, bad_reason}.
  - 36..2^addr_width_p-1: read as 0.
- Read FSM (IDLE, RESP):
  - IDLE: rd_ready_o=1. On rd_v_i, latch the addressed value as it stands before this cycle's increment/clear, go to RESP.
  - RESP: rd_ready_o=0, rd_data_v_o=1, rd_data_o held stable. On rd_data_yumi_i, go to IDLE.
  - No back-to-back acceptance: minimum 2 cycles per read. Latency is 1 cycle from acceptance to rd_data_v_o.
  - rd_data_o holds its last value while in IDLE.
- rd_data_yumi_i while rd_data_v_o=0 is a protocol error and is ignored.
- Async reset asserted mid-read: the response is dropped and the FSM returns to IDLE.

Test Plan:
- Reset, then 10 cycles freeze_i=0 with no events → read addr 34 returns 10, addr 33 returns 0, addr 35 returns 0; rd_data_v_o exactly 1 cycle after acceptance.
- 5 events instret=1, 3 events reason=6 (dcache_miss), 2 events reason=32 → reads of 33/6/32 return 5/3/2; addr 0 returns 0.
- Event with reason=40 → addr 0 returns 1, addr 35 returns 1 (bad_reason); then clear_i pulse with a same-cycle reason=6 event → addrs 0, 6 and 35 all read 0.
- ctr_width_p=4 build, 20 events reason=1 → addr 1 reads 15, addr 35 reads 2 (saturated); the counter still reads 15 after 5 more events.
- Request accepted while rd_data_yumi_i is withheld 4 cycles → rd_ready_o=0 and rd_data_o stable for all 4 cycles; a read accepted in the same cycle as a reason=6 increment returns the pre-increment value; freeze_i=1 for 8 cycles leaves the cycle counter unchanged.
- reset_li pulsed low while in RESP → rd_data_v_o=0 immediately (async), all counters 0, rd_ready_o=1 on the first edge after release.
